count_controller: RTL and testbench

Sequencer for the 8-bit lab counter datapath: owns an 8-bit up-count register and decides when it advances. It divides Clock by a programmable prescale, starts, pauses, stops and restarts the count, detects a programmable terminal count, and either halts there or auto-reloads. It sits between the board-level buttons/switches and the count display, replacing a free-running enabled counter with a controlled timer.

---
 rtl/count_controller.sv | 112 +++++++++++
 tb/tb_count_controller.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/count_controller.sv
// Sequencer for the 8-bit lab counter: prescaled ticks, start/stop/pause control,
// and a programmable terminal count that either halts or reloads.
module count_controller #(
  parameter int unsigned PRESCALE_W = 16
) (
  input  logic                  clock,
  input  logic                  resetn,
  input  logic                  start,
  input  logic                  stop,
  input  logic                  pause,
  input  logic                  auto_reload,
  input  logic [PRESCALE_W-1:0] prescale,
  input  logic [7:0]            terminal,
  output logic                  enable,
  output logic [7:0]            counter_value,
  output logic                  busy,
  output logic                  done
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    PAUSED = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [PRESCALE_W-1:0] pre_q, pre_d;
  logic [PRESCALE_W-1:0] p_q, p_d;
  logic [7:0]            t_q, t_d;
  logic                  ar_q, ar_d;
  logic [7:0]            count_d;
  logic                  done_d;
  logic                  tick_c;
  logic [7:0]            count_inc;

  // State and datapath registers
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q       <= IDLE;
      pre_q         <= '0;
      p_q           <= '0;
      t_q           <= '0;
      ar_q          <= 1'b0;
      counter_value <= '0;
      done          <= 1'b0;
    end else begin
      state_q       <= state_d;
      pre_q         <= pre_d;
      p_q           <= p_d;
      t_q           <= t_d;
      ar_q          <= ar_d;
      counter_value <= count_d;
      done          <= done_d;
    end
  end

  assign count_inc = counter_value + 8'd1;
  assign tick_c    = (state_q == RUN) && (pre_q == p_q) && !pause && !stop && !start;
  assign enable    = tick_c;
  assign busy      = (state_q != IDLE);

  // Command decode: stop beats start beats pause
  always_comb begin
    state_d = state_q;
    pre_d   = pre_q;
    p_d     = p_q;
    t_d     = t_q;
    ar_d    = ar_q;
    count_d = counter_value;
    done_d  = 1'b0;

    if (stop) begin
      state_d = IDLE;
      pre_d   = '0;
    end else if (start) begin
      state_d = RUN;
      pre_d   = '0;
      count_d = '0;
      p_d     = prescale;
      t_d     = terminal;
      ar_d    = auto_reload;
    end else begin
      case (state_q)
        RUN: begin
          if (pause) begin
            state_d = PAUSED;
          end else if (pre_q == p_q) begin
            pre_d = '0;
            if (count_inc == t_q) begin
              done_d = 1'b1;
              if (ar_q) begin
                count_d = '0;
              end else begin
                count_d = t_q;
                state_d = IDLE;
              end
            end else begin
              count_d = count_inc;
            end
          end else begin
            pre_d = pre_q + PRESCALE_W'(1);
          end
        end
        PAUSED: begin
          if (!pause) state_d = RUN;
        end
        default: state_d = state_q;
      endcase
    end
  end

endmodule

// File: tb/tb_count_controller.sv
// Randomized and directed bench for count_controller against a cycle-level
// reference model built from tick countdowns and integer counts.
module tb_count_controller;

  localparam int unsigned PW = 16;

  logic          clock = 1'b0;
  logic          resetn;
  logic          start, stop, pause, auto_reload;
  logic [PW-1:0] prescale;
  logic [7:0]    terminal;
  logic          enable, busy, done;
  logic [7:0]    counter_value;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state
  bit          m_busy, m_paused, m_ar, m_done;
  int unsigned m_left, m_cnt, m_p, m_t;

  count_controller #(.PRESCALE_W(PW)) dut (
    .clock        (clock),
    .resetn       (resetn),
    .start        (start),
    .stop         (stop),
    .pause        (pause),
    .auto_reload  (auto_reload),
    .prescale     (prescale),
    .terminal     (terminal),
    .enable       (enable),
    .counter_value(counter_value),
    .busy         (busy),
    .done         (done)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input int unsigned got, input int unsigned exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_busy = 0; m_paused = 0; m_ar = 0; m_done = 0;
    m_left = 0; m_cnt = 0; m_p = 0; m_t = 0;
  endtask

  function automatic bit model_tick();
    return m_busy && !m_paused && (m_left == 0) && !pause && !stop && !start;
  endfunction

  // Advance the model by one clock edge using the currently applied inputs
  task automatic model_step();
    bit tick;
    int unsigned nxt;
    tick   = model_tick();
    m_done = 0;
    if (!resetn) begin
      model_reset();
    end else if (stop) begin
      m_busy = 0; m_paused = 0;
    end else if (start) begin
      m_busy = 1; m_paused = 0; m_cnt = 0;
      m_p = prescale; m_t = terminal; m_ar = auto_reload;
      m_left = m_p;
    end else if (m_busy && m_paused) begin
      if (!pause) m_paused = 0;
    end else if (m_busy) begin
      if (pause) begin
        m_paused = 1;
      end else if (tick) begin
        m_left = m_p;
        nxt = (m_cnt + 1) % 256;
        if (nxt == m_t) begin
          m_done = 1;
          if (m_ar) m_cnt = 0;
          else begin
            m_cnt  = m_t;
            m_busy = 0;
          end
        end else begin
          m_cnt = nxt;
        end
      end else begin
        m_left = m_left - 1;
      end
    end
  endtask

  // One clock: compare at the falling edge, then step model and DUT together
  task automatic cycle();
    @(negedge clock);
    chk("enable", 32'(enable), 32'(model_tick()));
    chk("count",  32'(counter_value), m_cnt);
    chk("busy",   32'(busy), 32'(m_busy));
    chk("done",   32'(done), 32'(m_done));
    model_step();
    @(posedge clock);
    #1;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic do_start(input int p, input int t, input bit ar);
    prescale = PW'(p); terminal = 8'(t); auto_reload = ar;
    start = 1'b1;
    cycle();
    start = 1'b0;
  endtask

  // Assert reset between edges and confirm outputs clear without a clock
  task automatic async_reset();
    #2 resetn = 1'b0;
    #1;
    chk("arst_count",  32'(counter_value), 0);
    chk("arst_busy",   32'(busy), 0);
    chk("arst_done",   32'(done), 0);
    chk("arst_enable", 32'(enable), 0);
    model_reset();
    run(2);
    resetn = 1'b1;
  endtask

  int pause_left;

  initial begin
    resetn = 1'b0;
    start = 0; stop = 0; pause = 0; auto_reload = 0;
    prescale = '0; terminal = '0;
    model_reset();
    #1;
    run(2);
    resetn = 1'b1;
    run(2);

    // One-shot, P=0, T=5
    do_start(0, 5, 0);
    run(8);
    chk("t1_hold", 32'(counter_value), 5);
    chk("t1_idle", 32'(busy), 0);

    // Reload, P=3, T=3
    do_start(3, 3, 1);
    run(30);

    // Full 256-tick wrap one-shot
    stop = 1; cycle(); stop = 0;
    do_start(0, 0, 0);
    run(260);
    chk("t3_end", 32'(counter_value), 0);
    chk("t3_idle", 32'(busy), 0);

    // Pause straddling a tick cycle
    do_start(2, 10, 0);
    run(4);
    pause = 1; run(7); pause = 0;
    run(40);
    chk("t4_hold", 32'(counter_value), 10);

    // Stop at count 4, restart to T=2, then start+stop together
    do_start(0, 9, 0);
    run(4);
    stop = 1; cycle(); stop = 0;
    run(3);
    chk("t5_hold", 32'(counter_value), 4);
    chk("t5_idle", 32'(busy), 0);
    do_start(0, 2, 0);
    run(5);
    chk("t5_end", 32'(counter_value), 2);
    start = 1; stop = 1; cycle(); start = 0; stop = 0;
    run(2);
    chk("t5_stopwins", 32'(busy), 0);

    // Reset mid-run at count 7
    do_start(0, 20, 0);
    run(7);
    chk("t6_pre", 32'(counter_value), 7);
    async_reset();
    do_start(0, 3, 0);
    run(5);

    // Start with Pause high restarts into RUN
    pause = 1; do_start(1, 4, 1); run(3); pause = 0; run(12);

    // Randomized phase
    pause_left = 0;
    for (int i = 0; i < 4000; i++) begin
      start = ($urandom_range(0, 39) == 0);
      stop  = ($urandom_range(0, 99) == 0);
      if (pause_left > 0) begin
        pause = 1'b1;
        pause_left--;
      end else begin
        pause = 1'b0;
        if ($urandom_range(0, 24) == 0) pause_left = int'($urandom_range(1, 8));
      end
      prescale    = PW'($urandom_range(0, 3));
      auto_reload = ($urandom_range(0, 1) == 1);
      case ($urandom_range(0, 9))
        0:       terminal = 8'd0;
        1:       terminal = 8'd1;
        default: terminal = 8'($urandom_range(2, 12));
      endcase
      if ($urandom_range(0, 999) == 0) async_reset();
      else cycle();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
